// File: rtl/player_shooter_pkg.sv
// Shared game constants and the player-side state encoding.
package player_shooter_pkg;

    localparam int NUM_COLS         = 20;
    localparam int PLAYER_ROW       = 15;
    localparam int BULLET_START_ROW = 14;
    localparam int PARK_ROW         = 0;
    localparam int PLAYER_RESET_X   = 10;

    typedef enum logic [1:0] {
        WAIT_START = 2'd0,
        READY      = 2'd1,
        FLYING     = 2'd2
    } shooter_state_t;

endpackage

// File: rtl/timer_1us.sv
// Free-running microsecond timer: one-cycle tick every US microseconds.
module timer_1us #(
    parameter int US = 1
) (
    input  logic clk_36MHz,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CLKS_PER_US = 36;
    localparam int UW = (US > 1) ? $clog2(US) : 1;

    logic [5:0]    cyc_cnt;
    logic [UW-1:0] us_cnt;
    logic          cyc_wrap;
    logic          us_wrap;

    assign cyc_wrap = (cyc_cnt == 6'(CLKS_PER_US - 1));
    assign us_wrap  = (us_cnt == UW'(US - 1));

    always_ff @(posedge clk_36MHz) begin
        if (!reset) begin
            cyc_cnt <= '0;
            us_cnt  <= '0;
            tick    <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (en) begin
                if (cyc_wrap) begin
                    cyc_cnt <= '0;
                    if (us_wrap) begin
                        us_cnt <= '0;
                        tick   <= 1'b1;
                    end else begin
                        us_cnt <= us_cnt + 1'b1;
                    end
                end else begin
                    cyc_cnt <= cyc_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/player_shooter.sv
// Cannon position, single player bullet and hit score.
module player_shooter
    import player_shooter_pkg::*;
#(
    parameter int BULLET_US = 20000,
    parameter int PLAYER_US = 50000
) (
    input  logic       clk_36MHz,
    input  logic       reset,
    input  logic       start,
    input  logic       fire,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       hit,
    output logic [4:0] bullet_x,
    output logic [3:0] bullet_y,
    output logic       bullet_active,
    output logic [4:0] player_x,
    output logic [7:0] score
);

    shooter_state_t state, state_n;
    logic [4:0] bullet_x_n;
    logic [3:0] bullet_y_n;
    logic       bullet_active_n;
    logic [4:0] player_x_n;
    logic [7:0] score_n;
    logic       fire_q;
    logic       hit_q;
    logic       bullet_tick;
    logic       player_tick;
    logic       fire_edge;
    logic       hit_edge;
    logic       in_game;

    timer_1us #(.US(BULLET_US)) u_bullet_timer (
        .clk_36MHz (clk_36MHz),
        .reset     (reset),
        .en        (1'b1),
        .tick      (bullet_tick)
    );

    timer_1us #(.US(PLAYER_US)) u_player_timer (
        .clk_36MHz (clk_36MHz),
        .reset     (reset),
        .en        (1'b1),
        .tick      (player_tick)
    );

    assign fire_edge = fire & ~fire_q;
    assign hit_edge  = hit & ~hit_q;
    assign in_game   = (state != WAIT_START);

    always_ff @(posedge clk_36MHz) begin
        if (!reset) begin
            state         <= WAIT_START;
            bullet_x      <= '0;
            bullet_y      <= 4'(PARK_ROW);
            bullet_active <= 1'b0;
            player_x      <= 5'(PLAYER_RESET_X);
            score         <= '0;
            fire_q        <= 1'b0;
            hit_q         <= 1'b0;
        end else begin
            state         <= state_n;
            bullet_x      <= bullet_x_n;
            bullet_y      <= bullet_y_n;
            bullet_active <= bullet_active_n;
            player_x      <= player_x_n;
            score         <= score_n;
            fire_q        <= fire;
            hit_q         <= hit;
        end
    end

    always_comb begin
        state_n         = state;
        bullet_x_n      = bullet_x;
        bullet_y_n      = bullet_y;
        bullet_active_n = bullet_active;
        player_x_n      = player_x;
        score_n         = score;

        unique case (state)
            WAIT_START: begin
                if (start)
                    state_n = READY;
            end
            READY: begin
                if (fire_edge) begin
                    state_n         = FLYING;
                    bullet_x_n      = player_x;
                    bullet_y_n      = 4'(BULLET_START_ROW);
                    bullet_active_n = 1'b1;
                end
            end
            FLYING: begin
                // A hit outranks the tick so a coincident tick never moves it
                if (hit_edge || (bullet_tick && bullet_y == 4'd1)) begin
                    state_n         = READY;
                    bullet_y_n      = 4'(PARK_ROW);
                    bullet_active_n = 1'b0;
                end else if (bullet_tick) begin
                    bullet_y_n = bullet_y - 1'b1;
                end
            end
            default: state_n = WAIT_START;
        endcase

        if (in_game && hit_edge && score != 8'hFF)
            score_n = score + 1'b1;

        if (in_game && player_tick) begin
            if (move_left && !move_right &&
                player_x != 5'(NUM_COLS - 1))
                player_x_n = player_x + 1'b1;
            else if (move_right && !move_left &&
                     player_x != 5'd0)
                player_x_n = player_x - 1'b1;
        end
    end

endmodule

// File: doc/player_shooter.md
# player_shooter

Player-side counterpart of the invader formation block. It owns the cannon's column and the single player bullet, and drives `bullet_x`/`bullet_y` into the invader block. It consumes that block's `hit` flag to retire the bullet and to keep a hit score. It sits between the debounced button inputs and the invader block in the game top level.

## Interface

Parameters:
- `BULLET_US`, default 20000: bullet step period in µs, passed to a `timer_1us` instance.
- `PLAYER_US`, default 50000: cannon step period in µs, passed to a second `timer_1us` instance.

Ports (reset is synchronous, active-low; clock is `clk_36MHz`):
- `clk_36MHz`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  level; leaves WAIT_START.
- `fire`  in  1  level, already debounced and synchronized.
- `move_left`  in  1  level; increments the column.
- `move_right`  in  1  level; decrements the column.
- `hit`  in  1  from the invader block; may stay high for up to 2 cycles per hit.
- `bullet_x`  out  5  bullet column, 0..19.
- `bullet_y`  out  4  bullet row; 0 means parked/no bullet.
- `bullet_active`  out  1  high while a bullet is in flight.
- `player_x`  out  5  cannon column, 0..19.
- `score`  out  8  count of hits, saturating at 255.

## Operation

Reset values (when `reset==0`): state WAIT_START, `bullet_x`=0, `bullet_y`=0, `bullet_active`=0, `player_x`=10, `score`=0, `fire_q`=0, `hit_q`=0.

Coordinates:
- Row 15 is the cannon row; rows decrease upward.
- Invaders collide only at rows 1..14, so `bullet_y`=0 can never produce a hit.

State machine (register outputs in every state):
- WAIT_START
  - `start==1` goes to READY.
  - Buttons and `hit` are ignored.
- READY
  - A fire rising edge (`fire && !fire_q`) goes to FLYING.
  - On that transition: `bullet_x` ← `player_x`, `bullet_y` ← 14, `bullet_active` ← 1.
  - Holding `fire` does not re-launch; a release is needed first.
- FLYING
  - A hit rising edge (`hit && !hit_q`) has top priority. It goes to READY with `bullet_y` ← 0 and `bullet_active` ← 0.
  - Otherwise, on a bullet tick with `bullet_y==1`, go to READY and park the bullet (it left the playfield).
  - Otherwise, on a bullet tick, `bullet_y` ← `bullet_y`−1.
  - `bullet_x` is frozen for the whole flight.
  - Fire edges are ignored.

Score:
- `score` increments on every hit rising edge in READY or FLYING.
- This covers a hit that arrives one cycle after a tick-retirement.
- `score` holds at 255 when saturated.

Cannon:
- Moves on each player tick in READY and FLYING.
- `move_left` alone: `player_x`+1, clamped at 19.
- `move_right` alone: `player_x`−1, clamped at 0.
- Both or neither pressed: hold.

Reset mid-flight drops the bullet immediately and returns all state to the reset values.

## Timing

- Launch latency: a fire edge sampled at cycle N gives `bullet_y`=14 and `bullet_active`=1 at N+1. A bullet tick at cycle N does not move the new bullet.
- Hit response: a hit edge sampled at N gives a parked bullet and an updated `score` at N+1.
- If a hit edge and a bullet tick land in the same cycle, the hit wins and the bullet parks (it does not decrement).
- Flight length without a hit: 14 bullet ticks from launch to park.
- Cannon latency: one cycle after the player tick.
- `fire_q` and `hit_q` are plain one-cycle delay registers, updated every cycle except during reset.

## Structure

- Shared game package holds:
  - `NUM_COLS`=20, `PLAYER_ROW`=15, `BULLET_START_ROW`=14, `PARK_ROW`=0, `PLAYER_RESET_X`=10.
  - The state encoding WAIT_START/READY/FLYING.
- Sub-modules: two instances of the existing `timer_1us`, with `en` tied to 1.
  - No new sub-module is needed; the FSM, edge detectors and counters are flat in `player_shooter`.

## Test plan

- Reset, then `start` pulse, then fire edge with `player_x`=10 → next cycle `bullet_x`=10, `bullet_y`=14, `bullet_active`=1.
- No hit, `BULLET_US`=2 → `bullet_y` steps 14→1 on successive ticks, then goes to 0 with `bullet_active`=0 at the 14th tick; `score` stays 0.
- `hit` held high for 2 cycles during flight → bullet parked next cycle, `score`=1 (not 2). A second fire edge then launches again.
- `move_left` held for 15 player ticks from reset → `player_x` clamps at 19. `move_right` held for 25 ticks → clamps at 0. Both held → no change.
- Edge cases:
  - Fire held continuously → exactly one launch.
  - Fire edge in WAIT_START → no bullet.
  - `reset`=0 mid-flight → all outputs return to reset values next cycle.
- Hit edge coinciding with a bullet tick at `bullet_y`=5 → parked with `bullet_y`=0 (not 4) and `score`+1.
- Force `score`=255, then hit → `score` stays 255.
